// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: round-robin arbiter that multiplexes byte streams from
// several requesters onto a single USB device-controller transmit port.
// A granted requester holds the port until it sends its last byte or
// stalls for too long; a fixed idle gap separates consecutive packets.
module usb_tx_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned STALL_MAX  = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [7:0]             core_data_in,
   output logic                   core_send_data,
   input  logic                   core_ready,
   output logic                   abort,
   output logic                   busy
);

   localparam int unsigned IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [7:0]  STALL_LIM = 8'(STALL_MAX);
   localparam logic [3:0]  GAP_LAST  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t         state;
   logic [IW-1:0]  gidx;
   logic [IW-1:0]  ptr;
   logic [7:0]     stall;
   logic [3:0]     gap_cnt;

   logic           g_valid;
   logic           g_last;
   logic [7:0]     g_data;
   logic           xfer;
   logic           stall_hit;
   logic           arb_found;
   logic [IW-1:0]  arb_idx;

   // Select the granted requester's byte-lane signals
   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = 8'h00;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (gidx == IW'(i)) begin
            g_valid = req_valid[i];
            g_last  = req_last[i];
            g_data  = req_data[i*8 +: 8];
         end
      end
   end

   // Round-robin search starting just after the last granted index
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = ptr;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         if (!arb_found && req[IW'((int'(ptr) + k) % int'(NUM_REQ))]) begin
            arb_found = 1'b1;
            arb_idx   = IW'((int'(ptr) + k) % int'(NUM_REQ));
         end
      end
   end

   // Zero-latency pass-through; a pending byte always wins over a stall abort
   always_comb begin
      xfer           = !rst && (state == XFER) && g_valid && core_ready;
      stall_hit      = !rst && (state == XFER) && !g_valid && (stall == STALL_LIM);
      req_ready      = xfer ? (NUM_REQ'(1) << gidx) : '0;
      core_send_data = xfer;
      core_data_in   = xfer ? g_data : 8'h00;
      abort          = stall_hit;
      busy           = !rst && (state != IDLE);
   end

   // Arbitration FSM: grant, stall counting, packet release and inter-packet gap
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         gidx    <= '0;
         ptr     <= IW'(NUM_REQ - 1);
         stall   <= 8'd0;
         gap_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_found) begin
                  state <= XFER;
                  gnt   <= NUM_REQ'(1) << arb_idx;
                  gidx  <= arb_idx;
                  stall <= 8'd0;
               end
            end
            XFER: begin
               if ((xfer && g_last) || stall_hit) begin
                  gnt     <= '0;
                  ptr     <= gidx;
                  stall   <= 8'd0;
                  gap_cnt <= 4'd0;
                  state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
               end else if (xfer) begin
                  stall <= 8'd0;
               end else if (!g_valid) begin
                  stall <= stall + 8'd1;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
